// File: rtl/diag_parity_decoder.sv
// Two-stage decoder/corrector for the 34-bit diagonal/parity codeword (16 data + 18 check bits).
// Stage 1 captures data and syndrome; stage 2 corrects, classifies and presents the word.
module diag_parity_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [33:0]      code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      data_out,
  output logic [17:0]      syndrome_out,
  output logic             err_corr,
  output logic             err_chk,
  output logic             err_uncorr,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] corr_cnt,
  output logic [CNT_W-1:0] uncorr_cnt
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned CHK_W  = 18;
  localparam int unsigned WT_W   = 5;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Check-bit equations; also yields each data bit's signature when fed a one-hot word.
  function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] x);
    logic [CHK_W-1:0] c;
    c[0]  = x[2] ^ x[0];
    c[1]  = x[3] ^ x[1];
    c[2]  = x[3] ^ x[7] ^ x[11] ^ x[15];
    c[3]  = x[3] ^ x[6] ^ x[11] ^ x[14];
    c[4]  = x[6] ^ x[4];
    c[5]  = x[7] ^ x[5];
    c[6]  = x[2] ^ x[6] ^ x[10] ^ x[14];
    c[7]  = x[2] ^ x[7] ^ x[10] ^ x[15];
    c[8]  = x[10] ^ x[8];
    c[9]  = x[11] ^ x[9];
    c[10] = x[1] ^ x[5] ^ x[9] ^ x[13];
    c[11] = x[1] ^ x[4] ^ x[9] ^ x[12];
    c[12] = x[14] ^ x[12];
    c[13] = x[15] ^ x[13];
    c[14] = x[0] ^ x[4] ^ x[8] ^ x[12];
    c[15] = x[0] ^ x[5] ^ x[8] ^ x[13];
    c[16] = x[2] ^ x[5] ^ x[10] ^ x[13];
    c[17] = x[1] ^ x[6] ^ x[9] ^ x[14];
    return c;
  endfunction

  logic              en_c;
  logic              hs_c;
  logic [DATA_W-1:0] fix_mask_c;
  logic [WT_W-1:0]   weight_c;
  logic              is_sig_c;
  logic              is_zero_c;
  logic              one_hot_c;

  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_data_q,  s1_data_d;
  logic [CHK_W-1:0]  s1_synd_q,  s1_synd_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] data_q,     data_d;
  logic [CHK_W-1:0]  synd_q,     synd_d;
  logic              corr_q,     corr_d;
  logic              chk_q,      chk_d;
  logic              uncorr_q,   uncorr_d;
  logic [CNT_W-1:0]  corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0]  uncorr_cnt_q, uncorr_cnt_d;

  assign en_c = !out_valid_q || out_ready;
  assign hs_c = out_valid_q && out_ready;

  // Syndrome classification for the word held in stage 1.
  always_comb begin
    fix_mask_c = '0;
    weight_c   = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (s1_synd_q == calc_chk(DATA_W'(1) << i)) fix_mask_c[i] = 1'b1;
    end
    for (int k = 0; k < CHK_W; k++) begin
      weight_c = weight_c + WT_W'(s1_synd_q[k]);
    end
    is_sig_c  = |fix_mask_c;
    is_zero_c = (s1_synd_q == '0);
    one_hot_c = (weight_c == WT_W'(1));
  end

  // Next-state for both pipeline stages and the counters.
  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_data_d    = s1_data_q;
    s1_synd_d    = s1_synd_q;
    out_valid_d  = out_valid_q;
    data_d       = data_q;
    synd_d       = synd_q;
    corr_d       = corr_q;
    chk_d        = chk_q;
    uncorr_d     = uncorr_q;
    corr_cnt_d   = corr_cnt_q;
    uncorr_cnt_d = uncorr_cnt_q;

    if (en_c) begin
      s1_valid_d  = in_valid;
      out_valid_d = s1_valid_q;
      if (in_valid) begin
        s1_data_d = code_in[15:0];
        s1_synd_d = code_in[33:16] ^ calc_chk(code_in[15:0]);
      end
      if (s1_valid_q) begin
        data_d   = s1_data_q ^ fix_mask_c;
        synd_d   = s1_synd_q;
        corr_d   = is_sig_c;
        chk_d    = !is_sig_c && one_hot_c;
        uncorr_d = !is_zero_c && !is_sig_c && !one_hot_c;
      end
    end

    // Clear takes priority over a same-cycle increment.
    if (cnt_clr) begin
      corr_cnt_d   = '0;
      uncorr_cnt_d = '0;
    end else if (hs_c) begin
      if ((corr_q || chk_q) && corr_cnt_q != CNT_MAX) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (uncorr_q && uncorr_cnt_q != CNT_MAX) uncorr_cnt_d = uncorr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_data_q    <= '0;
      s1_synd_q    <= '0;
      out_valid_q  <= 1'b0;
      data_q       <= '0;
      synd_q       <= '0;
      corr_q       <= 1'b0;
      chk_q        <= 1'b0;
      uncorr_q     <= 1'b0;
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_data_q    <= s1_data_d;
      s1_synd_q    <= s1_synd_d;
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      synd_q       <= synd_d;
      corr_q       <= corr_d;
      chk_q        <= chk_d;
      uncorr_q     <= uncorr_d;
      corr_cnt_q   <= corr_cnt_d;
      uncorr_cnt_q <= uncorr_cnt_d;
    end
  end

  assign in_ready     = en_c;
  assign out_valid    = out_valid_q;
  assign data_out     = data_q;
  assign syndrome_out = synd_q;
  assign err_corr     = corr_q;
  assign err_chk      = chk_q;
  assign err_uncorr   = uncorr_q;
  assign corr_cnt     = corr_cnt_q;
  assign uncorr_cnt   = uncorr_cnt_q;

endmodule

// File: tb/tb_diag_parity_decoder.sv
// Directed bench for diag_parity_decoder with hand-encoded codewords and a 4-bit counter build.
module tb_diag_parity_decoder;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [33:0]   code_in;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   data_out;
  logic [17:0]   syndrome_out;
  logic          err_corr;
  logic          err_chk;
  logic          err_uncorr;
  logic          cnt_clr;
  logic [CW-1:0] corr_cnt;
  logic [CW-1:0] uncorr_cnt;

  int errors = 0;
  int checks = 0;
  int exp_corr = 0;
  int exp_uncorr = 0;

  // Stream vectors: codes built by hand from the check equations (0xA5C3 encodes to 0x088BB).
  logic [33:0] s_code [8] = '{
    {18'h00000, 16'h0000}, {18'h00000, 16'hFFFF}, {18'h0C001, 16'h0001}, {18'h18420, 16'h0020},
    {18'h088BB, 16'hA5C3}, {18'h088BB, 16'hA5E3}, {18'h00000, 16'h8000}, {18'h00003, 16'h0000}};
  logic [15:0] s_data [8] = '{16'h0000, 16'hFFFF, 16'h0001, 16'h0020,
                              16'hA5C3, 16'hA5C3, 16'h0000, 16'h0000};
  logic [17:0] s_synd [8] = '{18'h0, 18'h0, 18'h0, 18'h0, 18'h0, 18'h18420, 18'h02084, 18'h00003};
  logic [2:0]  s_flag [8] = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 3'b100, 3'b001};

  diag_parity_decoder #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .code_in(code_in),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .syndrome_out(syndrome_out), .err_corr(err_corr), .err_chk(err_chk),
    .err_uncorr(err_uncorr), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v < 15) ? v + 1 : 15;
  endfunction

  task automatic count_expected(input logic [2:0] f);
    if (f[2] || f[1]) exp_corr = sat_inc(exp_corr);
    if (f[0]) exp_uncorr = sat_inc(exp_uncorr);
  endtask

  // One isolated word: checks latency, payload, flags, then counters after the handshake.
  task automatic run_word(input string tag, input logic [33:0] code, input logic [15:0] ed,
                          input logic [17:0] es, input logic [2:0] ef);
    in_valid  = 1'b1;
    code_in   = code;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, "_lat1"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(data_out), 64'(ed));
    check({tag, "_synd"}, 64'(syndrome_out), 64'(es));
    check({tag, "_flags"}, 64'({err_corr, err_chk, err_uncorr}), 64'(ef));
    count_expected(ef);
    @(posedge clk); #1;
    check({tag, "_corr_cnt"}, 64'(corr_cnt), 64'(exp_corr));
    check({tag, "_uncorr_cnt"}, 64'(uncorr_cnt), 64'(exp_uncorr));
  endtask

  initial begin
    int tx;
    int rx;
    rst = 1'b1; in_valid = 1'b0; code_in = '0; out_ready = 1'b0; cnt_clr = 1'b0;
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_data", 64'(data_out), 64'd0);
    check("rst_synd", 64'(syndrome_out), 64'd0);
    check("rst_flags", 64'({err_corr, err_chk, err_uncorr}), 64'd0);
    check("rst_cnts", 64'({corr_cnt, uncorr_cnt}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_word("clean0", {18'h00000, 16'h0000}, 16'h0000, 18'h00000, 3'b000);
    run_word("corr_x5", {18'h088BB, 16'hA5E3}, 16'hA5C3, 18'h18420, 3'b100);
    run_word("chk_b20", {18'h088AB, 16'hA5C3}, 16'hA5C3, 18'h00010, 3'b010);
    run_word("uncorr_x01", {18'h088BB, 16'hA5C0}, 16'hA5C0, 18'h2CC03, 3'b001);

    // Back-to-back stream with a three-cycle consumer stall.
    tx = 0;
    rx = 0;
    for (int cyc = 0; cyc < 40 && rx < 8; cyc++) begin
      out_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (out_valid) begin
        if (!out_ready) begin
          check("stall_in_ready", 64'(in_ready), 64'd0);
          check("stall_hold_data", 64'(data_out), 64'(s_data[rx]));
          check("stall_hold_synd", 64'(syndrome_out), 64'(s_synd[rx]));
        end else begin
          check("strm_data", 64'(data_out), 64'(s_data[rx]));
          check("strm_synd", 64'(syndrome_out), 64'(s_synd[rx]));
          check("strm_flags", 64'({err_corr, err_chk, err_uncorr}), 64'(s_flag[rx]));
          count_expected(s_flag[rx]);
          rx++;
        end
      end
      if (tx < 8) begin
        in_valid = 1'b1;
        code_in  = s_code[tx];
        if (in_ready) tx++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("strm_delivered", 64'(rx), 64'd8);
    check("strm_sent", 64'(tx), 64'd8);
    check("strm_corr_cnt", 64'(corr_cnt), 64'(exp_corr));
    check("strm_uncorr_cnt", 64'(uncorr_cnt), 64'(exp_uncorr));
    @(posedge clk); #1;
    check("strm_no_dup", 64'(out_valid), 64'd0);

    // Asynchronous reset with words in flight.
    in_valid = 1'b1;
    code_in  = s_code[5];
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_cnts", 64'({corr_cnt, uncorr_cnt}), 64'd0);
    in_valid = 1'b0;
    exp_corr = 0;
    exp_uncorr = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    run_word("post_rst", {18'h0C001, 16'h0000}, 16'h0001, 18'h0C001, 3'b100);

    // Saturation: 20 more corrected words into a 4-bit counter.
    in_valid = 1'b1;
    code_in  = {18'h00000, 16'h0001};
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
    end
    check("sat_corr_cnt", 64'(corr_cnt), 64'd15);
    check("sat_uncorr_cnt", 64'(uncorr_cnt), 64'd0);

    // Clear coinciding with a corrected-word handshake.
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("clr_pre_valid", 64'(out_valid), 64'd1);
    check("clr_pre_cnt", 64'(corr_cnt), 64'd15);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("clr_corr_cnt", 64'(corr_cnt), 64'd0);
    check("clr_out_valid", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
